// File: rtl/bk_serial_adder.sv
// Nibble-serial adder: one 4-bit Brent-Kung adder is reused once per slice, with the carry held in a register.
// Optional signed-overflow output is enabled by defining BK_SERIAL_OVERFLOW_EN.

module brent_kung_cin (
  output logic [4:0] out,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;
  logic       w_g10;
  logic       w_p10;
  logic       w_g32;
  logic       w_p32;
  logic       w_g30;
  logic       w_p30;
  logic       w_cout;

  // Prefix tree: pairwise group terms, then a 4-wide group, then fill in the odd carry c3
  always_comb begin
    w_g    = A & B;
    w_p    = A ^ B;
    w_g10  = w_g[1] | (w_p[1] & w_g[0]);
    w_p10  = w_p[1] & w_p[0];
    w_g32  = w_g[3] | (w_p[3] & w_g[2]);
    w_p32  = w_p[3] & w_p[2];
    w_g30  = w_g32 | (w_p32 & w_g10);
    w_p30  = w_p32 & w_p10;
    w_c[0] = Cin;
    w_c[1] = w_g[0] | (w_p[0] & Cin);
    w_c[2] = w_g10 | (w_p10 & Cin);
    w_c[3] = w_g[2] | (w_p[2] & w_c[2]);
    w_cout = w_g30 | (w_p30 & Cin);
    out    = {w_cout, w_p ^ w_c};
  end

endmodule

module bk_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*NIBBLES:0] sum
`ifdef BK_SERIAL_OVERFLOW_EN
  ,
  output logic               ovf
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W:0]    r_sum;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          w_capture;
  logic          w_last;
  logic [CW+1:0] w_shift;
  logic [W-1:0]  w_a_sh;
  logic [W-1:0]  w_b_sh;
  logic [W-1:0]  w_mask;
  logic [W-1:0]  w_nib_sh;
  logic [4:0]    w_add;

  brent_kung_cin u_add (
    .out (w_add),
    .A   (w_a_sh[3:0]),
    .B   (w_b_sh[3:0]),
    .Cin (r_carry)
  );

  // Slice selection and placement: shift the active nibble down to the adder and its result back up
  always_comb begin
    w_capture = (r_state == S_IDLE) && in_valid;
    w_last    = (r_cnt == CW'(NIBBLES - 1));
    w_shift   = {r_cnt, 2'b00};
    w_a_sh    = r_a >> w_shift;
    w_b_sh    = r_b >> w_shift;
    w_mask    = W'(4'hF) << w_shift;
    w_nib_sh  = W'(w_add[3:0]) << w_shift;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_next = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next = S_DONE;
        end else begin
          w_next = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register and handshake flags, registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == S_IDLE);
      r_out_valid <= (w_next == S_DONE);
    end
  end

  // Operand capture and per-slice accumulation; sum is untouched outside RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= {W{1'b0}};
      r_b     <= {W{1'b0}};
      r_carry <= 1'b0;
      r_cnt   <= {CW{1'b0}};
      r_sum   <= {(W+1){1'b0}};
    end else if (w_capture) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_cnt   <= {CW{1'b0}};
    end else if (r_state == S_RUN) begin
      r_carry        <= w_add[4];
      r_sum[W-1:0]   <= (r_sum[W-1:0] & ~w_mask) | w_nib_sh;
      if (w_last) begin
        r_sum[W] <= w_add[4];
        r_cnt    <= r_cnt;
      end else begin
        r_sum[W] <= r_sum[W];
        r_cnt    <= r_cnt + CW'(1);
      end
    end else begin
      r_carry <= r_carry;
      r_cnt   <= r_cnt;
    end
  end

`ifdef BK_SERIAL_OVERFLOW_EN
  logic r_ovf;

  // Signed overflow judged on the top slice, same timing as the sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if ((r_state == S_RUN) && w_last) begin
      r_ovf <= (r_a[W-1] == r_b[W-1]) && (w_add[3] != r_a[W-1]);
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign ovf = r_ovf;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;

endmodule

// File: doc/bk_serial_adder.md
BK_SERIAL_ADDER -- requirements
Module: bk_serial_adder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NIBBLES  4  number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..8.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning. Clock and reset come first.
  clk        input   1    single clock; all state updates on the rising edge.
  rst        input   1    reset; asynchronous, active-high.
  in_valid   input   1    operand set offered.
  in_ready   output  1    block can accept an operand set.
  a          input   W    operand A.
  b          input   W    operand B.
  cin        input   1    carry-in.
  out_valid  output  1    result held on sum.
  out_ready  input   1    consumer accepts the result.
  sum        output  W+1  result {carry_out, W-bit sum}.
REQ-003 The block SHALL instantiate exactly one brent_kung_cin 4-bit adder. The adder port order SHALL be: out[4:0], A[3:0], B[3:0], Cin.
REQ-004 All arithmetic SHALL go through that one instance, one nibble per cycle.

Function
REQ-005 The block SHALL implement an FSM with three states: IDLE, RUN and DONE.
REQ-006 In IDLE, in_ready=1 and out_valid=0.
REQ-007 In IDLE, in_valid=1 SHALL capture a, b and cin into internal registers.
REQ-008 On that capture, the slice counter SHALL clear to 0 and the FSM SHALL move to RUN.
REQ-009 In RUN, in_ready=0, and in_valid SHALL be ignored.
REQ-010 In RUN, each cycle SHALL present nibble[k] of A and B, plus the carry register, to the adder.
REQ-011 Each RUN cycle SHALL register adder out[3:0] into sum bits [4k+3:4k].
REQ-012 Each RUN cycle SHALL register adder out[4] into the carry register.
REQ-013 The carry register SHALL be loaded with cin at capture.
REQ-014 When k = NIBBLES-1, the final carry SHALL be written to sum[W] and the FSM SHALL move to DONE.
REQ-015 Otherwise, k SHALL increment by one.
REQ-016 Latency SHALL be exactly NIBBLES+1 cycles: from the capture edge to the first cycle with out_valid=1.
REQ-017 In DONE, out_valid=1 and in_ready=0.
REQ-018 In DONE, sum SHALL hold stable until out_ready=1.
REQ-019 In DONE with out_ready=1, the FSM SHALL return to IDLE on that edge.
REQ-020 Back-pressure: out_ready=0 in DONE SHALL hold the state indefinitely, with sum unchanged.
REQ-021 A result SHALL never be dropped or overwritten before it is accepted.
REQ-022 There is no overlap: a new operand set SHALL be accepted no earlier than the cycle after the DONE handshake.
REQ-023 The result SHALL equal a + b + cin modulo 2^(W+1), for all inputs.
REQ-024 Boundary: a = b = all-ones with cin=1 SHALL give sum = 2^(W+1)-1; the carry propagates through every slice.
REQ-025 Boundary: NIBBLES=1 SHALL give a single RUN cycle with latency 2.
REQ-026 sum SHALL change only during RUN cycles and at reset; it SHALL keep its last value while in IDLE.

Reset
REQ-027 Asserting rst SHALL immediately force the following, independent of clk:
  - FSM to IDLE;
  - slice counter, carry register and operand registers to 0;
  - sum to 0, out_valid to 0, in_ready to 1.
REQ-028 rst asserted mid-RUN or mid-DONE SHALL abandon the operation; no out_valid pulse SHALL follow.
REQ-029 After rst deasserts, the first rising edge with in_valid=1 SHALL capture operands normally.

Configuration
REQ-030 The macro BK_SERIAL_OVERFLOW_EN, when defined, SHALL add an output port ovf (1 bit), placed after sum.
REQ-031 ovf SHALL be the two's-complement signed overflow of the W-bit sum.
REQ-032 ovf SHALL be computed from the most significant slice: (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]).
REQ-033 ovf SHALL be registered with the same timing as sum, reset to 0, and held through DONE.
REQ-034 When BK_SERIAL_OVERFLOW_EN is undefined, the ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification (NIBBLES=4 unless noted)
REQ-035 Basic add: a=0x0002, b=0x0001, cin=0, out_ready=1 -> out_valid rises exactly 5 cycles after capture, sum=0x00003.
REQ-036 Full carry chain: a=0xFFFF, b=0xFFFF, cin=1 -> sum=0x1FFFF.
REQ-037 Carry-in only: a=0xFFFF, b=0x0000, cin=1 -> sum=0x10000.
REQ-038 Back-pressure: out_ready held 0 for 10 cycles in DONE -> sum, out_valid=1 and in_ready=0 are stable throughout; in_ready returns to 1 the cycle after out_ready=1.
REQ-039 Reset mid-operation: rst pulsed on the 2nd RUN cycle -> in_ready=1, out_valid=0, sum=0 without waiting for clk; no result is emitted.
REQ-040 Overflow (BK_SERIAL_OVERFLOW_EN defined): a=0x7FFF, b=0x0001, cin=0 -> sum=0x08000, ovf=1; a=0x0001, b=0x0001 -> ovf=0.
